// File: rtl/sync_trig_tx.sv
// Transmit end of the coax trigger link: a per-frame spare window holding a sync burst,
// single-tick trigger pulses placed on one phase slot, and per-channel sent/drop counters.
module sync_trig_tx #(
  parameter int NCH        = 4,
  parameter int WINDOW     = 655,
  parameter int SYNC_START = 300,
  parameter int NSYNC      = 55,
  parameter int TX_PHASE   = 0
) (
  input  logic           clk_adc,
  input  logic           nrst,
  input  logic [7:0]     calibticks,
  input  logic [NCH-1:0] trig_in,
  input  logic           resetcnt,
  input  logic [7:0]     cnt_sel,
  output logic [NCH-1:0] coax_out,
  output logic           spare_out,
  output logic           sync_active,
  output logic [15:0]    cnt_sent,
  output logic [15:0]    cnt_drop
);

  typedef enum logic [2:0] {
    QUIET  = 3'b001,
    SYNC   = 3'b010,
    NORMAL = 3'b100
  } state_t;

  state_t         state, state_nxt;
  logic [31:0]    fcnt, fcnt_nxt;
  logic [1:0]     phase;
  logic [4:0]     wrap_bit;
  logic           wrap, in_win, win_end, slot, normal;
  logic [5:0]     burst_cnt, burst_nxt;
  logic           sync_fire, sync_nxt;
  logic [NCH-1:0] pend, pend_nxt, fire, trig_p1, drop_evt, coax_nxt;
  logic [15:0]    sent [NCH];
  logic [15:0]    drop [NCH];
  logic [15:0]    sent_mux, drop_mux;

  // Frame timing: the period is 2^k + 1 ticks because the counter reaches 2^k before clearing.
  always_comb begin
    wrap_bit = (calibticks > 8'd14) ? 5'd31 : calibticks[4:0] + 5'd17;
    wrap     = fcnt[wrap_bit];
    fcnt_nxt = wrap ? 32'd0 : fcnt + 32'd1;
    in_win   = (fcnt < 32'(WINDOW));
    win_end  = (fcnt >= 32'(WINDOW - 1));
    slot     = (phase == 2'(TX_PHASE));
    normal   = (state == NORMAL);
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    sync_fire = 1'b0;
    case (state)
      QUIET: begin
        if (win_end) begin
          state_nxt = NORMAL;
        end else if (slot && (fcnt >= 32'(SYNC_START)) && (burst_cnt != 6'(NSYNC))) begin
          sync_fire = 1'b1;
          burst_nxt = burst_cnt + 6'd1;
          if (burst_nxt != 6'(NSYNC)) state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (win_end) begin
          state_nxt = NORMAL;
        end else if (slot) begin
          sync_fire = 1'b1;
          burst_nxt = burst_cnt + 6'd1;
          // After the last pulse the rest of the window stays silent.
          if (burst_nxt == 6'(NSYNC)) state_nxt = QUIET;
        end
      end
      NORMAL:  state_nxt = NORMAL;
      default: state_nxt = QUIET;
    endcase
    if (wrap) begin
      state_nxt = QUIET;
      burst_nxt = '0;
    end
    sync_nxt = sync_fire || (state == SYNC);
  end

  // A request is held until the next slot; requests outside NORMAL are discarded.
  always_comb begin
    fire     = (normal && slot) ? pend : '0;
    pend_nxt = (normal && !wrap) ? (trig_in | (pend & ~fire)) : '0;
    drop_evt = normal ? '0 : (trig_in & ~trig_p1);
    coax_nxt = fire | {NCH{sync_fire}};
  end

  // Stage p0 -> p1: timing, mode and pulse decisions registered onto the outputs.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      fcnt        <= '0;
      phase       <= '0;
      state       <= QUIET;
      burst_cnt   <= '0;
      pend        <= '0;
      trig_p1     <= '0;
      coax_out    <= '0;
      spare_out   <= 1'b0;
      sync_active <= 1'b0;
    end else begin
      fcnt        <= fcnt_nxt;
      phase       <= wrap ? 2'd0 : phase + 2'd1;
      state       <= state_nxt;
      burst_cnt   <= burst_nxt;
      pend        <= pend_nxt;
      trig_p1     <= trig_in;
      coax_out    <= coax_nxt;
      spare_out   <= in_win;
      sync_active <= sync_nxt;
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NCH; i++) begin
        sent[i] <= '0;
        drop[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (resetcnt) begin
          sent[i] <= '0;
          drop[i] <= '0;
        end else begin
          if (fire[i])     sent[i] <= sent[i] + 16'd1;
          if (drop_evt[i]) drop[i] <= drop[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    sent_mux = '0;
    drop_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_sel == 8'(i)) begin
        sent_mux = sent[i];
        drop_mux = drop[i];
      end
    end
  end

  // Stage p1 -> p2: counter readout.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      cnt_sent <= '0;
      cnt_drop <= '0;
    end else begin
      cnt_sent <= sent_mux;
      cnt_drop <= drop_mux;
    end
  end

endmodule

// File: tb/tb_sync_trig_tx.sv
// Randomized bench for sync_trig_tx against a tick-level reference model of the
// frame, the sync burst, slot placement of triggers and the monitoring counters.
module tb_sync_trig_tx;

  localparam int NCH        = 4;
  localparam int WINDOW     = 655;
  localparam int SYNC_START = 300;
  localparam int NSYNC      = 55;
  localparam int TXP        = 1;
  localparam int HMAX       = 4096;

  logic           clk_adc = 1'b0;
  logic           nrst;
  logic [7:0]     calibticks;
  logic [NCH-1:0] trig_in;
  logic           resetcnt;
  logic [7:0]     cnt_sel;
  logic [NCH-1:0] coax_out;
  logic           spare_out;
  logic           sync_active;
  logic [15:0]    cnt_sent;
  logic [15:0]    cnt_drop;

  sync_trig_tx #(
    .NCH(NCH), .WINDOW(WINDOW), .SYNC_START(SYNC_START), .NSYNC(NSYNC), .TX_PHASE(TXP)
  ) dut (
    .clk_adc(clk_adc), .nrst(nrst), .calibticks(calibticks), .trig_in(trig_in),
    .resetcnt(resetcnt), .cnt_sel(cnt_sel), .coax_out(coax_out), .spare_out(spare_out),
    .sync_active(sync_active), .cnt_sent(cnt_sent), .cnt_drop(cnt_drop)
  );

  always #5 clk_adc = ~clk_adc;

  int             n_tests = 0;
  int             n_fail  = 0;
  int             t;
  logic [NCH-1:0] hist [HMAX];
  logic [NCH-1:0] last_trig;
  logic [15:0]    exp_sent [NCH];
  logic [15:0]    exp_drop [NCH];
  int             obs [NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One frame tick: inputs held now belong to tick t; the registered result is sampled after the edge.
  task automatic step();
    logic [NCH-1:0] ec;
    logic           es, ey, rc;
    int             first, last;
    hist[t] = trig_in;
    rc      = resetcnt;
    @(posedge clk_adc);
    #1;
    first = SYNC_START + ((TXP - (SYNC_START % 4) + 4) % 4);
    last  = first + 4 * (NSYNC - 1);
    ec = '0;
    if (t >= first && t <= last && ((t - first) % 4) == 0) ec = '1;
    if (t >= WINDOW && (t % 4) == TXP)
      for (int r = t - 4; r < t; r++)
        if (r >= WINDOW) ec |= hist[r];
    es = (t < WINDOW);
    ey = (t >= first && t <= last);
    chk($sformatf("coax t=%0d", t), 32'(coax_out), 32'(ec));
    chk($sformatf("spare t=%0d", t), 32'(spare_out), 32'(es));
    chk($sformatf("sync t=%0d", t), 32'(sync_active), 32'(ey));
    for (int c = 0; c < NCH; c++) begin
      if (coax_out[c]) obs[c]++;
      if (rc) begin
        exp_sent[c] = '0;
        exp_drop[c] = '0;
      end else begin
        if (t >= WINDOW && ec[c]) exp_sent[c] = exp_sent[c] + 16'd1;
        if (t < WINDOW && hist[t][c] && !last_trig[c]) exp_drop[c] = exp_drop[c] + 16'd1;
      end
    end
    last_trig = hist[t];
    t++;
  endtask

  task automatic run_to(input int target);
    trig_in  = '0;
    resetcnt = 1'b0;
    while (t < target) step();
  endtask

  task automatic read_sel(input int ch);
    cnt_sel = 8'(ch);
    step();
    step();
  endtask

  task automatic check_cnts();
    for (int s = 0; s <= NCH; s++) begin
      if (s == NCH) begin
        read_sel(200);
        chk("sent_oor", 32'(cnt_sent), 32'd0);
        chk("drop_oor", 32'(cnt_drop), 32'd0);
      end else begin
        read_sel(s);
        chk($sformatf("sent%0d", s), 32'(cnt_sent), 32'(exp_sent[s]));
        chk($sformatf("drop%0d", s), 32'(cnt_drop), 32'(exp_drop[s]));
      end
    end
  endtask

  task automatic hold_reset();
    trig_in  = '0;
    resetcnt = 1'b0;
    nrst     = 1'b0;
    #1;
    chk("rst_coax", 32'(coax_out), 32'd0);
    chk("rst_spare", 32'(spare_out), 32'd0);
    chk("rst_sync", 32'(sync_active), 32'd0);
    repeat (2) @(posedge clk_adc);
    #1;
    chk("rst_sent", 32'(cnt_sent), 32'd0);
    chk("rst_drop", 32'(cnt_drop), 32'd0);
    chk("rst_coax_hold", 32'(coax_out), 32'd0);
    nrst      = 1'b1;
    t         = 0;
    last_trig = '0;
    for (int c = 0; c < NCH; c++) begin
      exp_sent[c] = '0;
      exp_drop[c] = '0;
      obs[c]      = 0;
    end
  endtask

  // Edge taken while the frame counter is parked far from the window.
  task automatic raw_edge(input string tag, input logic exp_spare);
    @(posedge clk_adc);
    #1;
    chk({tag, "_spare"}, 32'(spare_out), 32'(exp_spare));
    chk({tag, "_coax"}, 32'(coax_out), 32'd0);
    chk({tag, "_sync"}, 32'(sync_active), 32'd0);
  endtask

  initial begin
    logic [NCH-1:0] v;
    int             base, s;
    nrst       = 1'b1;
    calibticks = 8'd0;
    trig_in    = '0;
    resetcnt   = 1'b0;
    cnt_sel    = 8'd0;
    t          = 0;
    @(posedge clk_adc);
    #1;
    hold_reset();

    // Window: random requests on 0/2/3, five isolated requests on channel 1.
    while (t < WINDOW) begin
      v = '0;
      for (int c = 0; c < NCH; c++)
        if (c != 1 && $urandom_range(0, 7) == 0) v[c] = 1'b1;
      if (t == 50 || t == 120 || t == 200 || t == 350 || t == 420) v[1] = 1'b1;
      if (t == WINDOW - 2 || t == WINDOW - 1) v[0] = 1'b1;
      trig_in = v;
      step();
    end
    chk("burst_ch1", 32'(obs[1]), 32'(NSYNC));
    chk("burst_ch3", 32'(obs[3]), 32'(NSYNC));
    trig_in = 4'b1000;
    step();
    run_to(880);
    read_sel(1);
    chk("drop1_const", 32'(cnt_drop), 32'd5);
    check_cnts();

    // Single request on channel 2.
    run_to(1000);
    base    = obs[2];
    trig_in = 4'b0100;
    step();
    run_to(1010);
    chk("ch2_single", 32'(obs[2] - base), 32'd1);
    read_sel(2);
    chk("sent2_const", 32'(cnt_sent), 32'd1);

    // Sustained request on channel 0 starting on a slot tick.
    run_to(1101);
    base    = obs[0];
    trig_in = 4'b0001;
    repeat (20) step();
    run_to(1135);
    chk("ch0_hold", 32'(obs[0] - base), 32'd5);
    read_sel(0);
    chk("sent0_const", 32'(cnt_sent), 32'd5);

    while (t < 1550) begin
      for (int c = 0; c < NCH; c++) v[c] = ($urandom_range(0, 3) == 0);
      trig_in = v;
      step();
    end
    run_to(1560);
    check_cnts();

    // Counter clear coinciding with a sent pulse on channel 3.
    s = t + 4 + ((TXP - ((t + 4) % 4) + 4) % 4);
    run_to(s - 2);
    trig_in = 4'b1000;
    step();
    run_to(s);
    resetcnt = 1'b1;
    step();
    run_to(s + 6);
    read_sel(3);
    chk("sent3_clr", 32'(cnt_sent), 32'd0);
    check_cnts();

    // Reset during the 20th sync pulse, then a full burst after release.
    hold_reset();
    run_to(SYNC_START + ((TXP - (SYNC_START % 4) + 4) % 4) + 4 * 19);
    step();
    chk("pulse20", 32'(coax_out), 32'hF);
    hold_reset();
    run_to(700);
    for (int c = 0; c < NCH; c++) chk($sformatf("burst_rst%0d", c), 32'(obs[c]), 32'(NSYNC));

    // Wrap at 2^17 with calibticks = 0 starts a new frame with a full burst.
    calibticks = 8'd0;
    force dut.fcnt = 32'h0001_FFFF;
    #1;
    release dut.fcnt;
    raw_edge("w17a", 1'b0);
    raw_edge("w17b", 1'b0);
    t         = 0;
    last_trig = '0;
    for (int c = 0; c < NCH; c++) obs[c] = 0;
    run_to(700);
    for (int c = 0; c < NCH; c++) chk($sformatf("burst_wrap%0d", c), 32'(obs[c]), 32'(NSYNC));

    // calibticks = 200 clamps to 14: 2^17 no longer wraps, 2^31 does.
    calibticks = 8'd200;
    force dut.fcnt = 32'h0001_FFFF;
    #1;
    release dut.fcnt;
    raw_edge("nw17a", 1'b0);
    raw_edge("nw17b", 1'b0);
    raw_edge("nw17c", 1'b0);
    force dut.fcnt = 32'h7FFF_FFFF;
    #1;
    release dut.fcnt;
    raw_edge("w31a", 1'b0);
    raw_edge("w31b", 1'b0);
    t         = 0;
    last_trig = '0;
    run_to(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
